// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared types and constants for the RV32 control decode stage:
//                the decoded control bundle, opcode values, immediate-format
//                encodings and an immediate builder.
//  Revision    : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       memtoreg;
        logic       operandbsel;
        logic       branch;
        logic [1:0] operandasel;
        logic [1:0] nextpcsel;
        logic [2:0] extendsel;
        logic [2:0] aluop;
    } ctrl_t;

    // Supported major opcodes
    localparam logic [6:0] c_op_rtype  = 7'h33;
    localparam logic [6:0] c_op_load   = 7'h03;
    localparam logic [6:0] c_op_store  = 7'h23;
    localparam logic [6:0] c_op_branch = 7'h63;
    localparam logic [6:0] c_op_itype  = 7'h13;
    localparam logic [6:0] c_op_jalr   = 7'h67;
    localparam logic [6:0] c_op_jal    = 7'h6F;
    localparam logic [6:0] c_op_lui    = 7'h37;
    localparam logic [6:0] c_op_auipc  = 7'h17;

    // Immediate format selects
    localparam logic [2:0] c_ext_i = 3'b000;
    localparam logic [2:0] c_ext_u = 3'b001;
    localparam logic [2:0] c_ext_s = 3'b010;
    localparam logic [2:0] c_ext_b = 3'b011;
    localparam logic [2:0] c_ext_j = 3'b100;

    // Builds the 32-bit immediate for a given format; bit 31 of the
    // instruction is always the sign source.
    function automatic logic [31:0] build_imm32(input logic [31:0] instr,
                                                input logic [2:0]  extendsel);
        logic [31:0] imm;
        case (extendsel)
            c_ext_i: imm = {{20{instr[31]}}, instr[31:20]};
            c_ext_u: imm = {instr[31:12], 12'b0};
            c_ext_s: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            c_ext_b: imm = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            c_ext_j: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decoder
//  Description : Purely combinational RV32 opcode and immediate decoder.
//  Ports       : i_instr   - raw 32-bit instruction
//                o_ctrl    - decoded control bundle (all zero when illegal)
//                o_imm     - sign-extended immediate (zero when illegal)
//                o_illegal - opcode not supported
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output ctrl_t           o_ctrl,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    ctrl_t       w_ctrl;
    logic        w_legal;
    logic [31:0] w_imm32;

    always_comb begin
        w_ctrl  = '0;
        w_legal = 1'b1;
        case (i_instr[6:0])
            c_op_rtype: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.aluop    = 3'b000;
            end
            c_op_load: begin
                w_ctrl.memread     = 1'b1;
                w_ctrl.memtoreg    = 1'b1;
                w_ctrl.regwrite    = 1'b1;
                w_ctrl.operandbsel = 1'b1;
                w_ctrl.extendsel   = c_ext_i;
                w_ctrl.aluop       = 3'b100;
            end
            c_op_store: begin
                w_ctrl.memwrite    = 1'b1;
                w_ctrl.operandbsel = 1'b1;
                w_ctrl.extendsel   = c_ext_s;
                w_ctrl.aluop       = 3'b101;
            end
            c_op_branch: begin
                w_ctrl.branch    = 1'b1;
                w_ctrl.nextpcsel = 2'b01;
                w_ctrl.extendsel = c_ext_b;
                w_ctrl.aluop     = 3'b010;
            end
            c_op_itype: begin
                w_ctrl.regwrite    = 1'b1;
                w_ctrl.operandbsel = 1'b1;
                w_ctrl.extendsel   = c_ext_i;
                w_ctrl.aluop       = 3'b001;
            end
            c_op_jalr: begin
                w_ctrl.regwrite    = 1'b1;
                w_ctrl.operandasel = 2'b01;
                w_ctrl.extendsel   = c_ext_i;
                w_ctrl.nextpcsel   = 2'b11;
                w_ctrl.aluop       = 3'b011;
            end
            c_op_jal: begin
                w_ctrl.regwrite    = 1'b1;
                w_ctrl.operandasel = 2'b01;
                w_ctrl.extendsel   = c_ext_j;
                w_ctrl.nextpcsel   = 2'b10;
                w_ctrl.aluop       = 3'b011;
            end
            c_op_lui: begin
                w_ctrl.regwrite    = 1'b1;
                w_ctrl.operandasel = 2'b10;
                w_ctrl.operandbsel = 1'b1;
                w_ctrl.extendsel   = c_ext_u;
                w_ctrl.aluop       = 3'b110;
            end
            c_op_auipc: begin
                w_ctrl.regwrite    = 1'b1;
                w_ctrl.operandasel = 2'b01;
                w_ctrl.operandbsel = 1'b1;
                w_ctrl.extendsel   = c_ext_u;
                w_ctrl.aluop       = 3'b111;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_imm32   = build_imm32(i_instr, w_ctrl.extendsel);
    // Signed cast widens the 32-bit immediate to XLEN with sign extension.
    assign o_imm     = w_legal ? XLEN'($signed(w_imm32)) : '0;
    assign o_ctrl    = w_ctrl;
    assign o_illegal = ~w_legal;

endmodule
`default_nettype wire

// File: rtl/ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode_stage
//  Description : One-cycle RV32 decode pipeline stage with valid/ready
//                handshakes on both sides and an optional skid register that
//                keeps in_ready_o free of any combinational path from
//                out_ready_i.
//  Ports       : clk_i, rst_ni (async, active low), flush_i
//                in_valid_i/in_ready_o, instr_i, pc_i      - upstream
//                out_valid_o/out_ready_i, ctrl_o, imm_o,
//                instr_o, pc_o, illegal_o                   - downstream
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output ctrl_t           ctrl_o,
    output logic [XLEN-1:0] imm_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            illegal_o
);

    // Single decoder shared by the output and skid registers
    ctrl_t           w_dec_ctrl;
    logic [XLEN-1:0] w_dec_imm;
    logic            w_dec_illegal;

    ctrl_decoder #(
        .XLEN (XLEN)
    ) u_decoder (
        .i_instr   (instr_i),
        .o_ctrl    (w_dec_ctrl),
        .o_imm     (w_dec_imm),
        .o_illegal (w_dec_illegal)
    );

    logic            r_out_valid;
    ctrl_t           r_out_ctrl;
    logic [XLEN-1:0] r_out_imm;
    logic [31:0]     r_out_instr;
    logic [XLEN-1:0] r_out_pc;
    logic            r_out_illegal;

    logic            w_skid_valid;
    ctrl_t           w_skid_ctrl;
    logic [XLEN-1:0] w_skid_imm;
    logic [31:0]     w_skid_instr;
    logic [XLEN-1:0] w_skid_pc;
    logic            w_skid_illegal;

    logic            w_in_xfer;
    logic            w_out_load;

    assign w_in_xfer  = in_valid_i & in_ready_o;
    // Output register may take new content when empty or being drained.
    assign w_out_load = ~r_out_valid | out_ready_i;

    generate
        if (SKID_EN) begin : g_skid
            logic            r_skid_valid;
            ctrl_t           r_skid_ctrl;
            logic [XLEN-1:0] r_skid_imm;
            logic [31:0]     r_skid_instr;
            logic [XLEN-1:0] r_skid_pc;
            logic            r_skid_illegal;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_skid_valid   <= 1'b0;
                    r_skid_ctrl    <= '0;
                    r_skid_imm     <= '0;
                    r_skid_instr   <= '0;
                    r_skid_pc      <= '0;
                    r_skid_illegal <= 1'b0;
                end else if (flush_i) begin
                    r_skid_valid <= 1'b0;
                end else if (r_skid_valid && w_out_load) begin
                    // Entry migrates into the output register this cycle.
                    r_skid_valid <= 1'b0;
                end else if (w_in_xfer && !w_out_load) begin
                    r_skid_valid   <= 1'b1;
                    r_skid_ctrl    <= w_dec_ctrl;
                    r_skid_imm     <= w_dec_imm;
                    r_skid_instr   <= instr_i;
                    r_skid_pc      <= pc_i;
                    r_skid_illegal <= w_dec_illegal;
                end
            end

            // Registered ready: only depends on skid occupancy.
            assign in_ready_o     = ~r_skid_valid;
            assign w_skid_valid   = r_skid_valid;
            assign w_skid_ctrl    = r_skid_ctrl;
            assign w_skid_imm     = r_skid_imm;
            assign w_skid_instr   = r_skid_instr;
            assign w_skid_pc      = r_skid_pc;
            assign w_skid_illegal = r_skid_illegal;
        end else begin : g_no_skid
            assign in_ready_o     = ~r_out_valid | out_ready_i;
            assign w_skid_valid   = 1'b0;
            assign w_skid_ctrl    = '0;
            assign w_skid_imm     = '0;
            assign w_skid_instr   = '0;
            assign w_skid_pc      = '0;
            assign w_skid_illegal = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid   <= 1'b0;
            r_out_ctrl    <= '0;
            r_out_imm     <= '0;
            r_out_instr   <= '0;
            r_out_pc      <= '0;
            r_out_illegal <= 1'b0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
        end else if (w_out_load) begin
            if (w_skid_valid) begin
                // Older skid entry goes first to keep program order; input is
                // blocked whenever the skid is occupied.
                r_out_valid   <= 1'b1;
                r_out_ctrl    <= w_skid_ctrl;
                r_out_imm     <= w_skid_imm;
                r_out_instr   <= w_skid_instr;
                r_out_pc      <= w_skid_pc;
                r_out_illegal <= w_skid_illegal;
            end else if (w_in_xfer) begin
                r_out_valid   <= 1'b1;
                r_out_ctrl    <= w_dec_ctrl;
                r_out_imm     <= w_dec_imm;
                r_out_instr   <= instr_i;
                r_out_pc      <= pc_i;
                r_out_illegal <= w_dec_illegal;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign ctrl_o      = r_out_ctrl;
    assign imm_o       = r_out_imm;
    assign instr_o     = r_out_instr;
    assign pc_o        = r_out_pc;
    assign illegal_o   = r_out_illegal;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_decode_stage
//  Description : Directed self-checking bench for ctrl_decode_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_decode_stage;
    import ctrl_pkg::*;

    localparam int XLEN = 32;

    logic            clk_i;
    logic            rst_ni;
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    ctrl_t           ctrl_o;
    logic [XLEN-1:0] imm_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] pc_o;
    logic            illegal_o;

    ctrl_decode_stage #(
        .XLEN    (XLEN),
        .SKID_EN (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .instr_i     (instr_i),
        .pc_i        (pc_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .ctrl_o      (ctrl_o),
        .imm_o       (imm_o),
        .instr_o     (instr_o),
        .pc_o        (pc_o),
        .illegal_o   (illegal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Field order matches ctrl_t
    function automatic ctrl_t mk(input logic rw, input logic mw, input logic mr,
                                 input logic mt, input logic bs, input logic br,
                                 input logic [1:0] as, input logic [1:0] np,
                                 input logic [2:0] es, input logic [2:0] op);
        ctrl_t c;
        c.regwrite = rw; c.memwrite = mw; c.memread = mr; c.memtoreg = mt;
        c.operandbsel = bs; c.branch = br; c.operandasel = as;
        c.nextpcsel = np; c.extendsel = es; c.aluop = op;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid_i = v;
        instr_i    = ins;
        pc_i       = pc;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 64'(out_valid_o), 64'd0);
        check({tag, ".ctrl"},  64'(ctrl_o),      64'd0);
        check({tag, ".imm"},   64'(imm_o),       64'd0);
        check({tag, ".instr"}, 64'(instr_o),     64'd0);
        check({tag, ".pc"},    64'(pc_o),        64'd0);
        check({tag, ".ill"},   64'(illegal_o),   64'd0);
        check({tag, ".rdy"},   64'(in_ready_o),  64'd1);
    endtask

    localparam int NV = 10;
    logic [31:0] v_instr [NV];
    ctrl_t       v_ctrl  [NV];
    logic [31:0] v_imm   [NV];
    logic        v_ill   [NV];

    localparam logic [31:0] INS_A = 32'h00A00093;
    localparam logic [31:0] INS_B = 32'h123450B7;

    initial begin
        v_instr[0] = 32'h00A00093; v_ctrl[0] = mk(1,0,0,0,1,0,2'b00,2'b00,3'b000,3'b001); v_imm[0] = 32'h0000000A; v_ill[0] = 0;
        v_instr[1] = 32'h123450B7; v_ctrl[1] = mk(1,0,0,0,1,0,2'b10,2'b00,3'b001,3'b110); v_imm[1] = 32'h12345000; v_ill[1] = 0;
        v_instr[2] = 32'hFE20AE23; v_ctrl[2] = mk(0,1,0,0,1,0,2'b00,2'b00,3'b010,3'b101); v_imm[2] = 32'hFFFFFFFC; v_ill[2] = 0;
        v_instr[3] = 32'hFE000EE3; v_ctrl[3] = mk(0,0,0,0,0,1,2'b00,2'b01,3'b011,3'b010); v_imm[3] = 32'hFFFFFFFC; v_ill[3] = 0;
        v_instr[4] = 32'h008000EF; v_ctrl[4] = mk(1,0,0,0,0,0,2'b01,2'b10,3'b100,3'b011); v_imm[4] = 32'h00000008; v_ill[4] = 0;
        v_instr[5] = 32'h80000117; v_ctrl[5] = mk(1,0,0,0,1,0,2'b01,2'b00,3'b001,3'b111); v_imm[5] = 32'h80000000; v_ill[5] = 0;
        v_instr[6] = 32'h00008067; v_ctrl[6] = mk(1,0,0,0,0,0,2'b01,2'b11,3'b000,3'b011); v_imm[6] = 32'h00000000; v_ill[6] = 0;
        v_instr[7] = 32'hFFF12083; v_ctrl[7] = mk(1,0,1,1,1,0,2'b00,2'b00,3'b000,3'b100); v_imm[7] = 32'hFFFFFFFF; v_ill[7] = 0;
        v_instr[8] = 32'h00000033; v_ctrl[8] = mk(1,0,0,0,0,0,2'b00,2'b00,3'b000,3'b000); v_imm[8] = 32'h00000000; v_ill[8] = 0;
        v_instr[9] = 32'h0000007F; v_ctrl[9] = '0;                                         v_imm[9] = 32'h00000000; v_ill[9] = 1;

        rst_ni = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        // Reset state
        #12;
        check_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Back-to-back stream, downstream always ready: no bubbles
        out_ready_i = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, v_instr[i], 32'h1000 + 32'(i) * 4);
            check($sformatf("rdy%0d", i), 64'(in_ready_o), 64'd1);
            tick();
            check($sformatf("v%0d.valid", i), 64'(out_valid_o), 64'd1);
            check($sformatf("v%0d.ctrl", i),  64'(ctrl_o),      64'(v_ctrl[i]));
            check($sformatf("v%0d.imm", i),   64'(imm_o),       64'(v_imm[i]));
            check($sformatf("v%0d.ill", i),   64'(illegal_o),   64'(v_ill[i]));
            check($sformatf("v%0d.instr", i), 64'(instr_o),     64'(v_instr[i]));
            check($sformatf("v%0d.pc", i),    64'(pc_o),        64'(32'h1000 + 32'(i) * 4));
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("drain.valid", 64'(out_valid_o), 64'd0);

        // Skid: A and B accepted while downstream stalls, then drained in order
        out_ready_i = 1'b0;
        drive(1'b1, INS_A, 32'h200);
        tick();
        check("skA.valid", 64'(out_valid_o), 64'd1);
        check("skA.rdy",   64'(in_ready_o),  64'd1);
        drive(1'b1, INS_B, 32'h204);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("skB.rdy",   64'(in_ready_o), 64'd0);
        check("skB.instr", 64'(instr_o),    64'(INS_A));
        tick();
        check("hold.instr", 64'(instr_o), 64'(INS_A));
        check("hold.imm",   64'(imm_o),   64'h0000000A);
        check("hold.pc",    64'(pc_o),    64'h200);
        out_ready_i = 1'b1;
        #1;
        check("rdy.nocomb", 64'(in_ready_o), 64'd0);
        tick();
        check("dr1.valid", 64'(out_valid_o), 64'd1);
        check("dr1.instr", 64'(instr_o),     64'(INS_B));
        check("dr1.pc",    64'(pc_o),        64'h204);
        check("dr1.imm",   64'(imm_o),       64'h12345000);
        check("dr1.rdy",   64'(in_ready_o),  64'd1);
        tick();
        check("dr2.valid", 64'(out_valid_o), 64'd0);

        // Flush with both entries full
        out_ready_i = 1'b0;
        drive(1'b1, INS_A, 32'h300);
        tick();
        drive(1'b1, INS_B, 32'h304);
        tick();
        check("fl.full", 64'(in_ready_o), 64'd0);
        flush_i = 1'b1;
        drive(1'b1, 32'h00000013, 32'h308);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("fl.valid", 64'(out_valid_o), 64'd0);
        check("fl.rdy",   64'(in_ready_o),  64'd1);
        out_ready_i = 1'b1;
        drive(1'b1, 32'hFE20AE23, 32'h400);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("fl.next.instr", 64'(instr_o),     64'hFE20AE23);
        check("fl.next.valid", 64'(out_valid_o), 64'd1);
        tick();
        check("fl.alone", 64'(out_valid_o), 64'd0);

        // Flush ignores an input transfer in the same cycle
        flush_i = 1'b1;
        drive(1'b1, INS_A, 32'h500);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("fl.in.valid", 64'(out_valid_o), 64'd0);
        tick();
        check("fl.in.valid2", 64'(out_valid_o), 64'd0);

        // Asynchronous reset mid-stream
        out_ready_i = 1'b0;
        drive(1'b1, INS_A, 32'h600);
        tick();
        drive(1'b1, INS_B, 32'h604);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #2;
        rst_ni = 1'b0;
        #1;
        check_zero("arst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check("arst.after", 64'(out_valid_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ctrl_decode_stage.md
CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

Interface
REQ-001 The parameter XLEN SHALL default to 32 and set the width of the immediate and PC datapath.
REQ-002 The parameter SKID_EN SHALL default to 1; 1 enables the skid register, 0 removes it.
REQ-003 The port clk_i SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-004 The port rst_ni SHALL be an input, 1 bit wide, and be an asynchronous, active-low reset.
REQ-005 The port flush_i SHALL be an input, 1 bit wide, and discard all held instructions.
REQ-006 The port in_valid_i SHALL be an input, 1 bit wide, and mark that upstream instruction data is valid.
REQ-007 The port in_ready_o SHALL be an output, 1 bit wide, and indicate the stage can accept an instruction.
REQ-008 The port instr_i SHALL be an input, 32 bits wide, carrying the raw RV32 instruction.
REQ-009 The port pc_i SHALL be an input, XLEN bits wide, carrying the PC of instr_i.
REQ-010 The port out_valid_o SHALL be an output, 1 bit wide, and mark the decoded bundle as valid.
REQ-011 The port out_ready_i SHALL be an input, 1 bit wide, and indicate the downstream stage accepts the bundle.
REQ-012 The port ctrl_o SHALL be an output of type ctrl_t carrying the decoded control fields.
REQ-013 The port imm_o SHALL be an output, XLEN bits wide, carrying the sign-extended immediate.
REQ-014 The port instr_o SHALL be an output, 32 bits wide, carrying the instruction passed through.
REQ-015 The port pc_o SHALL be an output, XLEN bits wide, carrying the PC passed through.
REQ-016 The port illegal_o SHALL be an output, 1 bit wide, flagging an unsupported opcode.

Function
REQ-017 A transfer SHALL occur on an input or output port on a cycle where both its valid and its ready signals are 1.
REQ-018 Decode latency SHALL be 1 cycle: an accepted instruction appears on the outputs in the next cycle.
REQ-019 ctrl_t SHALL contain the following fields:
- regwrite, memwrite, memread, memtoreg, operandbsel, branch: 1 bit each
- operandasel, nextpcsel: 2 bits each
- extendsel: 3 bits (I=000, U=001, S=010, B=011, J=100)
- aluop: 3 bits
REQ-020 Opcode decode SHALL be:
- 0x33: regwrite=1, aluop=000
- 0x03: memread=1, memtoreg=1, regwrite=1, bsel=1, extendsel=I, aluop=100
- 0x23: memwrite=1, bsel=1, extendsel=S, aluop=101
- 0x63: branch=1, nextpcsel=01, extendsel=B, aluop=010
- 0x13: regwrite=1, bsel=1, extendsel=I, aluop=001
- 0x67: regwrite=1, asel=01, extendsel=I, nextpcsel=11, aluop=011
- 0x6F: regwrite=1, asel=01, extendsel=J, nextpcsel=10, aluop=011
- 0x37: regwrite=1, asel=10, bsel=1, extendsel=U, aluop=110
- 0x17 (new): regwrite=1, asel=01, bsel=1, extendsel=U, aluop=111
REQ-021 Any other opcode SHALL produce illegal_o=1, with every ctrl_o field 0 and imm_o=0; it SHALL NOT raise a simulation error.
REQ-022 imm_o SHALL be built per extendsel from instruction bit 31 and sign-extended to XLEN; U-type SHALL be {instr[31:12], 12'b0} sign-extended.
REQ-023 With SKID_EN=1, in_ready_o SHALL equal NOT skid_valid, registered and not combinationally dependent on out_ready_i.
REQ-024 If a transfer arrives while the output register is held (out_valid_o=1, out_ready_i=0), it SHALL be decoded into the skid register.
REQ-025 The skid entry SHALL move to the output register on the next output transfer, preserving program order.
REQ-026 With SKID_EN=0, in_ready_o SHALL equal (NOT out_valid_o) OR out_ready_i.
REQ-027 Output fields SHALL be held stable while out_valid_o=1 and out_ready_i=0.
REQ-028 flush_i=1 SHALL clear out_valid_o and skid_valid in the next cycle, and SHALL ignore an input transfer in the same cycle.
REQ-029 flush_i SHALL take priority over all simultaneous events.
REQ-030 A simultaneous output transfer and input transfer with an empty skid register SHALL refill the output register with no bubble.

Reset
REQ-031 While rst_ni=0, out_valid_o, the skid valid bit, ctrl_o, imm_o, instr_o, pc_o and illegal_o SHALL all be 0.
REQ-032 While rst_ni=0, in_ready_o SHALL be 1.
REQ-033 Reset asserted mid-transfer SHALL drop all held instructions.

Structure
REQ-034 ctrl_t, the opcode localparams and the extendsel encodings SHALL reside in package ctrl_pkg.
REQ-035 Combinational opcode and immediate decode SHALL be a sub-module ctrl_decoder (purely combinational), instantiated once and feeding both the output and skid registers.

Verification
REQ-036 Scenario: instr 0x00A00093 (addi x1,x0,10), out_ready=1 -> next cycle out_valid=1, regwrite=1, operandbsel=1, aluop=001, imm=0x0000000A.
REQ-037 Scenario: instr 0x123450B7 (lui) -> operandasel=10, extendsel=001, imm=0x12345000; instr 0xFE20AE23 (sw) -> memwrite=1, imm=0xFFFFFFFC.
REQ-038 Scenario: two instructions A, B sent while out_ready=0 -> in_ready=0 after B; then out_ready=1 -> A then B, one per cycle.
REQ-039 Scenario: instr 0x0000007F -> illegal_o=1 and regwrite=memwrite=branch=0.
REQ-040 Scenario: both entries full, flush_i=1 for 1 cycle -> out_valid=0 and in_ready=1 next cycle; the next accepted instruction emerges alone.
REQ-041 Scenario: rst_ni pulsed low asynchronously mid-stream -> all outputs 0 immediately.
